// File: rtl/filt_sched_if.sv
// filt_sched_if: groups the sample input, filter control, result output and status signals of filt_sched.
// Latency: none, wiring only.
// Backpressure: s_valid/s_ready on the sample side, m_valid/m_ready on the result side.
interface filt_sched_if #(
  parameter int DW = 16
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [1:0]    sel_req;
  logic [1:0]    sel_cur;
  logic          filt_start;
  logic [DW-1:0] filt_val;
  logic          filt_done;
  logic [DW-1:0] filt_result;
  logic          filt_rst;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          clr;
  logic          overflow;
  logic          err_timeout;

  // Environment side: sample source, filters datapath and result consumer.
  modport master (
    output s_valid, s_data, sel_req, filt_done, filt_result, m_ready, clr,
    input  s_ready, sel_cur, filt_start, filt_val, filt_rst, m_valid, m_data,
           overflow, err_timeout
  );

  // Scheduler side.
  modport slave (
    input  s_valid, s_data, sel_req, filt_done, filt_result, m_ready, clr,
    output s_ready, sel_cur, filt_start, filt_val, filt_rst, m_valid, m_data,
           overflow, err_timeout
  );
endinterface

// File: rtl/filt_sched.sv
// filt_sched: buffers ADC samples in a small FIFO and runs the filters once per sample (macro FILT_SCHED_STATS_EN adds counters).
// Latency: push to filt_start >= 2 cycles; filt_start to m_valid = 2 cycles in bypass, filter latency + 1 otherwise.
// Backpressure: no run starts while m_valid & ~m_ready; samples queue in the FIFO, a push while full is dropped and flagged.
module filt_sched #(
  parameter int DW      = 16,
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 256,
  parameter int RST_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  filt_sched_if.slave bus
`ifdef FILT_SCHED_STATS_EN
  ,
  output logic [31:0] stat_runs,
  output logic [15:0] stat_drops
`endif
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMEOUT);
  localparam int RW    = $clog2(RST_CYC + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX  = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_rdy_en;
  logic [TW-1:0]      r_tcnt;
  logic [RW-1:0]      r_rcnt;
  logic [1:0]         r_sel_cur;
  logic [DW-1:0]      r_filt_val;
  logic               r_m_valid;
  logic [DW-1:0]      r_m_data;
  logic               r_overflow;
  logic               r_err_timeout;

  logic w_full;
  logic w_empty;
  logic w_out_free;
  logic w_pop;
  logic w_push_ok;
  logic w_push;
  logic w_drop;
  logic w_cap;
  logic w_abort;

  assign w_full     = (r_count == CFULL);
  assign w_empty    = (r_count == '0);
  assign w_out_free = ~r_m_valid | bus.m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO may still take the push.
  assign w_push_ok  = r_rdy_en & (~w_full | w_pop);
  assign w_push     = bus.s_valid & w_push_ok;
  assign w_drop     = bus.s_valid & ~w_push_ok;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and per-cycle FSM strobes; filt_done only matters in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_cap       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_out_free) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.filt_done) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == TMAX) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_rcnt == RMAX) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.s_data;
  end

  // FIFO pointers and occupancy; s_ready is held off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Run setup: latch the select and the sample together so both stay fixed for the whole run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_cur  <= 2'b00;
      r_filt_val <= '0;
    end else if (w_pop) begin
      r_sel_cur  <= bus.sel_req;
      r_filt_val <= r_mem[r_rptr];
    end
  end

  // Timeout counter restarts in START; flush counter restarts on abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (r_state == ST_START)     r_tcnt <= '0;
      else if (r_state == ST_WAIT) r_tcnt <= r_tcnt + 1'b1;
      if (w_abort)                  r_rcnt <= '0;
      else if (r_state == ST_FLUSH) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // Result register: capture on done, release on m_ready, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_cap) begin
      r_m_valid <= 1'b1;
      r_m_data  <= bus.filt_result;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as clr takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_drop)       r_overflow <= 1'b1;
      else if (bus.clr) r_overflow <= 1'b0;
      if (w_abort)      r_err_timeout <= 1'b1;
      else if (bus.clr) r_err_timeout <= 1'b0;
    end
  end

`ifdef FILT_SCHED_STATS_EN
  logic [31:0] r_stat_runs;
  logic [15:0] r_stat_drops;

  // Saturating run and drop counters, zeroed by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_runs  <= '0;
      r_stat_drops <= '0;
    end else if (bus.clr) begin
      r_stat_runs  <= '0;
      r_stat_drops <= '0;
    end else begin
      if (w_cap && (r_stat_runs != '1))   r_stat_runs  <= r_stat_runs + 1'b1;
      if (w_drop && (r_stat_drops != '1)) r_stat_drops <= r_stat_drops + 1'b1;
    end
  end

  assign stat_runs  = r_stat_runs;
  assign stat_drops = r_stat_drops;
`endif

  assign bus.s_ready     = r_rdy_en & ~w_full;
  assign bus.sel_cur     = r_sel_cur;
  assign bus.filt_start  = (r_state == ST_START);
  assign bus.filt_val    = r_filt_val;
  assign bus.filt_rst    = (r_state == ST_FLUSH);
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.overflow    = r_overflow;
  assign bus.err_timeout = r_err_timeout;
endmodule
